// File: rtl/dpram_pkg.sv
// Shared definitions for the byte-enable dual-port RAM: read-during-write modes, clear FSM states
// and parameter helpers. Pure definitions, no latency, no flow control.
package dpram_pkg;

    localparam int WRITE_FIRST_MODE = 1;
    localparam int READ_FIRST_MODE  = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic bit params_ok(input int depth, input int addr_w, input int data_w,
                                     input int read_latency);
        return (data_w > 0) && (data_w % 8 == 0)
            && (read_latency == 1 || read_latency == 2)
            && (depth > 0) && (addr_w > 0) && (addr_w < 31)
            && ((64'd1 << addr_w) >= 64'(depth));
    endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Optional second read register per port; q/qvalid appear 0 or 1 clock after the array stage.
// No backpressure: every accepted read produces exactly one qvalid pulse.
module dpram_rd_pipe #(
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    output logic [DATA_W-1:0] q,
    output logic              qvalid
);

    logic [DATA_W-1:0] dat_q, dat_d;
    logic              vld_q, vld_d;

    always_comb begin
        dat_d = in_vld ? in_dat : dat_q;
        vld_d = in_vld;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dat_q <= '0;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    // The extra stage holds its word between reads just like the array stage does.
    assign q      = (READ_LATENCY == 2) ? dat_q : in_dat;
    assign qvalid = (READ_LATENCY == 2) ? vld_q : in_vld;

endmodule

// File: rtl/part_dpram_be.sv
// True dual-port RAM with byte enables and a clear/fill engine; reads return after READ_LATENCY clocks.
// No backpressure: writes during a clear are dropped, reads are always accepted.
module part_dpram_be
    import dpram_pkg::*;
#(
    parameter int                DEPTH          = 21504,
    parameter int                ADDR_W         = 15,
    parameter int                DATA_W         = 32,
    parameter int                READ_LATENCY   = 1,
    parameter int                WRITE_FIRST    = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    localparam int               BE_W           = be_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic [BE_W-1:0]   be_a,
    input  logic              wren_a,
    input  logic              rden_a,
    output logic [DATA_W-1:0] q_a,
    output logic              qvalid_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic [BE_W-1:0]   be_b,
    input  logic              wren_b,
    input  logic              rden_b,
    output logic [DATA_W-1:0] q_b,
    output logic              qvalid_b
);

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (!params_ok(DEPTH, ADDR_W, DATA_W, READ_LATENCY)) begin : g_bad_params
        $error("part_dpram_be: illegal parameter combination");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              auto_q, auto_d;

    logic              in_rng_a, in_rng_b;
    logic              we_a, we_b, clearing;
    logic [IDX_W-1:0]  idx_a, idx_b, idx_clr;
    logic [DATA_W-1:0] word_a, word_b;
    logic [DATA_W-1:0] rdat_a_q, rdat_a_d, rdat_b_q, rdat_b_d;
    logic              rvld_a_q, rvld_a_d, rvld_b_q, rvld_b_d;

    assign clearing   = (state_q == CLEAR);
    assign clear_busy = clearing;
    assign in_rng_a   = ({1'b0, address_a} < DEPTH_X);
    assign in_rng_b   = ({1'b0, address_b} < DEPTH_X);
    assign we_a       = wren_a && in_rng_a && !clearing;
    assign we_b       = wren_b && in_rng_b && !clearing;
    assign idx_a      = address_a[IDX_W-1:0];
    assign idx_b      = address_b[IDX_W-1:0];
    assign idx_clr    = cnt_q[IDX_W-1:0];

    // Clear engine: auto_q remembers a pending post-reset clear until IDLE can act on it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        auto_d  = auto_q;
        case (state_q)
            IDLE: begin
                if (clear_req || auto_q) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    auto_d  = 1'b0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            auto_q  <= CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            auto_q  <= auto_d;
        end
    end

    // Port B lanes are written first so that A's later assignment wins on shared lanes.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[idx_clr] <= CLEAR_VALUE;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (we_b && be_b[i]) mem[idx_b][8*i +: 8] <= data_b[8*i +: 8];
            end
            for (int i = 0; i < BE_W; i++) begin
                if (we_a && be_a[i]) mem[idx_a][8*i +: 8] <= data_a[8*i +: 8];
            end
        end
    end

    // Array reads see the pre-edge contents; write-first only folds in the same port's lanes.
    always_comb begin
        word_a = in_rng_a ? mem[idx_a] : '0;
        word_b = in_rng_b ? mem[idx_b] : '0;
        if (WRITE_FIRST == WRITE_FIRST_MODE) begin
            for (int i = 0; i < BE_W; i++) begin
                if (we_a && be_a[i]) word_a[8*i +: 8] = data_a[8*i +: 8];
                if (we_b && be_b[i]) word_b[8*i +: 8] = data_b[8*i +: 8];
            end
        end
        rdat_a_d = rden_a ? word_a : rdat_a_q;
        rdat_b_d = rden_b ? word_b : rdat_b_q;
        rvld_a_d = rden_a;
        rvld_b_d = rden_b;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdat_a_q <= '0;
            rdat_b_q <= '0;
            rvld_a_q <= 1'b0;
            rvld_b_q <= 1'b0;
        end else begin
            rdat_a_q <= rdat_a_d;
            rdat_b_q <= rdat_b_d;
            rvld_a_q <= rvld_a_d;
            rvld_b_q <= rvld_b_d;
        end
    end

    dpram_rd_pipe #(
        .DATA_W      (DATA_W),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe_a (
        .clk    (clk),
        .reset_n(reset_n),
        .in_vld (rvld_a_q),
        .in_dat (rdat_a_q),
        .q      (q_a),
        .qvalid (qvalid_a)
    );

    dpram_rd_pipe #(
        .DATA_W      (DATA_W),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe_b (
        .clk    (clk),
        .reset_n(reset_n),
        .in_vld (rvld_b_q),
        .in_dat (rdat_b_q),
        .q      (q_b),
        .qvalid (qvalid_b)
    );

endmodule
